// File: rtl/neuron_layer_scheduler.sv
// neuron_layer_scheduler
// Time-multiplexes one neuron datapath across every neuron of a fully-connected
// layer. For each neuron it fetches the weights and bias from the parameter ROM,
// loads them into the neuron, waits out the neuron latency and writes the
// neuron result into the layer result buffer. It also keeps a running signed
// argmax so that the layer directly reports the winning class.
//
// Ports:
//   clk, reset        clock, asynchronous active-low reset
//   start             run request, sampled only while idle
//   busy, done        run in progress / one-cycle completion pulse
//   rom_addr          neuron index into the parameter ROM (1-cycle read latency)
//   rom_weight/bias   ROM read data for rom_addr
//   neuron_weight/bias registered parameters driven into the neuron
//   neuron_output     neuron result, valid neuron_latency cycles after a load
//   out_we/addr/data  result buffer write port
//   class_idx/score   argmax of the last completed run
module neuron_layer_scheduler #(
    parameter int unsigned input_data_size = 4,
    parameter int unsigned resolution      = 8,
    parameter int unsigned num_neurons     = 10,
    parameter int unsigned neuron_latency  = 2,
    localparam int unsigned AW = (num_neurons > 1) ? $clog2(num_neurons) : 1,
    localparam int unsigned WW = resolution * input_data_size
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [AW-1:0]         rom_addr,
    input  logic [WW-1:0]         rom_weight,
    input  logic [resolution-1:0] rom_bias,
    output logic [WW-1:0]         neuron_weight,
    output logic [resolution-1:0] neuron_bias,
    input  logic [resolution-1:0] neuron_output,
    output logic                  out_we,
    output logic [AW-1:0]         out_addr,
    output logic [resolution-1:0] out_data,
    output logic [AW-1:0]         class_idx,
    output logic [resolution-1:0] class_score
);

    localparam int unsigned CW = (neuron_latency > 1) ? $clog2(neuron_latency + 1) : 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_LOAD  = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_STORE = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    logic [2:0]            state;
    logic [2:0]            next_state;
    logic [AW-1:0]         idx;
    logic [AW-1:0]         max_idx;
    logic [resolution-1:0] max_score;
    logic [CW-1:0]         cnt;

    logic                  last_c;
    logic                  take_c;
    logic [AW-1:0]         max_idx_c;
    logic [resolution-1:0] max_score_c;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic and running-argmax candidate
    always_comb begin
        next_state  = state;
        last_c      = (idx == AW'(num_neurons - 1));
        // Strict compare: on a tie the earlier (lower) index is kept.
        take_c      = (idx == '0) || ($signed(neuron_output) > $signed(max_score));
        max_score_c = take_c ? neuron_output : max_score;
        max_idx_c   = take_c ? idx : max_idx;

        case (state)
            S_IDLE:  if (start) next_state = S_FETCH;
            S_FETCH: next_state = S_LOAD;
            S_LOAD:  next_state = S_WAIT;
            S_WAIT:  if (cnt == CW'(1)) next_state = S_STORE;
            S_STORE: next_state = last_c ? S_DONE : S_FETCH;
            S_DONE:  next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // Datapath and registered status outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy          <= 1'b0;
            done          <= 1'b0;
            out_we        <= 1'b0;
            idx           <= '0;
            cnt           <= '0;
            max_idx       <= '0;
            max_score     <= '0;
            neuron_weight <= '0;
            neuron_bias   <= '0;
            class_idx     <= '0;
            class_score   <= '0;
        end else begin
            // Status flags are decoded from the upcoming state so they line up
            // with the state they describe.
            busy   <= (next_state != S_IDLE);
            done   <= (next_state == S_DONE);
            out_we <= (next_state == S_STORE);

            case (state)
                S_IDLE: begin
                    if (start) begin
                        idx       <= '0;
                        max_idx   <= '0;
                        max_score <= '0;
                    end
                end
                S_LOAD: begin
                    neuron_weight <= rom_weight;
                    neuron_bias   <= rom_bias;
                    cnt           <= CW'(neuron_latency);
                end
                S_WAIT: begin
                    cnt <= cnt - CW'(1);
                end
                S_STORE: begin
                    max_idx   <= max_idx_c;
                    max_score <= max_score_c;
                    if (last_c) begin
                        class_idx   <= max_idx_c;
                        class_score <= max_score_c;
                    end else begin
                        idx <= idx + AW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // idx is a register, so both addresses come straight from a flop.
    assign rom_addr = idx;
    assign out_addr = idx;

    // The neuron result only becomes valid in the STORE cycle itself, so the
    // write data is a gated pass-through behind the registered write strobe.
    assign out_data = out_we ? neuron_output : '0;

endmodule

// File: tb/tb_neuron_layer_scheduler.sv
// Testbench for neuron_layer_scheduler: a default instance (10 neurons,
// latency 2) checked every cycle against a run-level model, plus a
// single-neuron latency-1 instance checked with literal expectations.
module tb_neuron_layer_scheduler;

    localparam int N  = 10;
    localparam int L  = 2;
    localparam int P  = 3 + L;
    localparam int R  = 8;
    localparam int D  = 4;
    localparam int AW = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    logic start0;
    logic start1;

    int checks = 0;
    int errors = 0;

    // ---------------- default instance ----------------
    logic          busy0, done0, we0;
    logic [AW-1:0] rom_addr0, oaddr0, cidx0;
    logic [D*R-1:0] rom_weight0, nw0;
    logic [R-1:0]  rom_bias0, nb0, no0, odata0, cscore0;

    neuron_layer_scheduler dut0 (
        .clk(clk), .reset(reset), .start(start0),
        .busy(busy0), .done(done0),
        .rom_addr(rom_addr0), .rom_weight(rom_weight0), .rom_bias(rom_bias0),
        .neuron_weight(nw0), .neuron_bias(nb0), .neuron_output(no0),
        .out_we(we0), .out_addr(oaddr0), .out_data(odata0),
        .class_idx(cidx0), .class_score(cscore0)
    );

    // ---------------- single-neuron, latency-1 instance ----------------
    logic          busy1, done1, we1;
    logic [0:0]    rom_addr1, oaddr1, cidx1;
    logic [D*R-1:0] rom_weight1, nw1;
    logic [R-1:0]  rom_bias1, nb1, no1, odata1, cscore1;

    neuron_layer_scheduler #(
        .input_data_size(D), .resolution(R), .num_neurons(1), .neuron_latency(1)
    ) dut1 (
        .clk(clk), .reset(reset), .start(start1),
        .busy(busy1), .done(done1),
        .rom_addr(rom_addr1), .rom_weight(rom_weight1), .rom_bias(rom_bias1),
        .neuron_weight(nw1), .neuron_bias(nb1), .neuron_output(no1),
        .out_we(we1), .out_addr(oaddr1), .out_data(odata1),
        .class_idx(cidx1), .class_score(cscore1)
    );

    // ---------------- environment: ROM, neuron, input vector ----------------
    int rom_w [N][D];
    int rom_b [N];
    int in_vec [D] = '{1, 1, 1, 1};

    function automatic logic [D*R-1:0] pack_w(int n);
        logic [D*R-1:0] v;
        v = '0;
        for (int i = 0; i < D; i++) v[i*R +: R] = R'(rom_w[n][i]);
        return v;
    endfunction

    // Behavioural neuron: saturated dot(weights, input) + bias.
    function automatic logic [R-1:0] neuron_f(logic [D*R-1:0] w, logic [R-1:0] b);
        int s;
        logic signed [R-1:0] wi;
        logic signed [R-1:0] bs;
        bs = b;
        s = int'(bs);
        for (int i = 0; i < D; i++) begin
            wi = w[i*R +: R];
            s += int'(wi) * in_vec[i];
        end
        if (s > 127) s = 127;
        if (s < -128) s = -128;
        return R'(s);
    endfunction

    logic [R-1:0] p1_0, p2_0, p1_1;
    always @(posedge clk) begin
        rom_weight0 <= pack_w(int'(rom_addr0));
        rom_bias0   <= R'(rom_b[rom_addr0]);
        p1_0        <= neuron_f(nw0, nb0);
        p2_0        <= p1_0;
        // single-entry ROM for dut1: weights {3,2,1,-1}, bias -2 -> output 3
        rom_weight1 <= {8'hFF, 8'h01, 8'h02, 8'h03};
        rom_bias1   <= 8'hFE;
        p1_1        <= neuron_f(nw1, nb1);
    end
    assign no0 = p2_0;
    assign no1 = p1_1;

    // ---------------- run-level model of dut0 ----------------
    int           cyc = 0;
    bit           m_active = 1'b0;
    int           m_t0 = 0;
    logic [R-1:0] m_out [N];
    int           m_best_idx = 0;
    logic [R-1:0] m_best_score = '0;
    int           m_cls_idx = 0;
    logic [R-1:0] m_cls_score = '0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_active    = 1'b0;
            m_cls_idx   = 0;
            m_cls_score = '0;
        end else begin
            cyc++;
            if (m_active) begin
                if (cyc - m_t0 == 1 + N*P) begin
                    m_cls_idx   = m_best_idx;
                    m_cls_score = m_best_score;
                end
                if (cyc - m_t0 == 2 + N*P) m_active = 1'b0;
            end else if (start0) begin
                // t0 is the edge that began the cycle in which start was seen.
                m_active = 1'b1;
                m_t0     = cyc - 1;
                for (int n = 0; n < N; n++) m_out[n] = neuron_f(pack_w(n), R'(rom_b[n]));
                m_best_idx   = 0;
                m_best_score = m_out[0];
                for (int n = 1; n < N; n++) begin
                    if ($signed(m_out[n]) > $signed(m_best_score)) begin
                        m_best_idx   = n;
                        m_best_score = m_out[n];
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Result buffer image built from the write port.
    logic [R-1:0] buffer [N];

    // Per-cycle compare of dut0 against the model.
    always @(negedge clk) begin
        int  rel;
        int  n;
        bit  e_we;
        if (reset) begin
            rel  = cyc - m_t0;
            n    = -1;
            e_we = 1'b0;
            if (m_active && rel >= 1 && rel <= N*P) begin
                n    = (rel - 1) / P;
                e_we = ((rel - 1) % P) == P - 1;
            end
            check("busy", 32'(busy0), 32'(m_active));
            check("done", 32'(done0), 32'(m_active && rel == 1 + N*P));
            check("out_we", 32'(we0), 32'(e_we));
            if (n >= 0) check("rom_addr", 32'(rom_addr0), 32'(n));
            if (e_we) begin
                check("out_addr", 32'(oaddr0), 32'(n));
                check("out_data", 32'(odata0), 32'(m_out[n]));
                check("neuron_weight", nw0, pack_w(n));
                check("neuron_bias", 32'(nb0), 32'(R'(rom_b[n])));
            end
            check("class_idx", 32'(cidx0), 32'(m_cls_idx));
            check("class_score", 32'(cscore0), 32'(m_cls_score));
            if (we0 && int'(oaddr0) < N) buffer[oaddr0] = odata0;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_pattern_a();
        for (int n = 0; n < N; n++) begin
            rom_w[n] = '{n, 1, 1, 1};
            rom_b[n] = 1;
        end
    endtask

    task automatic set_pattern_vals(input int w0 [N], input int w1 [N], input int b [N]);
        for (int n = 0; n < N; n++) begin
            rom_w[n] = '{w0[n], w1[n], 0, 0};
            rom_b[n] = b[n];
        end
    endtask

    // Called #1 after a rising edge with dut0 idle; returns done latency from t0.
    task automatic run0(output int lat);
        int t0;
        start0 = 1'b1;
        t0 = cyc;
        @(posedge clk); #1;
        start0 = 1'b0;
        lat = -1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (done0) begin
                lat = cyc - t0;
                break;
            end
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
    endtask

    task automatic wait_done(output int at);
        at = -1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (done0) begin
                at = cyc;
                break;
            end
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int lat;
        int d_a;
        int d_b;
        int t0;
        int ndone;
        int wz0 [N];
        int wz1 [N];
        int bz [N];

        reset  = 1'b0;
        start0 = 1'b0;
        start1 = 1'b0;
        set_pattern_a();
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy0), 32'd0);
        check("rst_done", 32'(done0), 32'd0);
        check("rst_out_we", 32'(we0), 32'd0);
        check("rst_class_score", 32'(cscore0), 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (10) begin @(posedge clk); #1; end

        // Full run: outputs n+4, argmax 9 / 13, done at t0+51.
        run0(lat);
        check("lat_full", 32'(lat), 32'd51);
        check("lit_class_idx_a", 32'(cidx0), 32'd9);
        check("lit_class_score_a", 32'(cscore0), 32'd13);
        check("lit_buf0_a", 32'(buffer[0]), 32'd4);
        check("lit_buf9_a", 32'(buffer[9]), 32'd13);

        // Signed argmax with a tie and negatives.
        wz0 = '{-128, 5, 7, -3, 7, 0, 0, 0, 0, 0};
        wz1 = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        bz  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        set_pattern_vals(wz0, wz1, bz);
        run0(lat);
        check("lat_argmax", 32'(lat), 32'd51);
        check("lit_class_idx_b", 32'(cidx0), 32'd2);
        check("lit_class_score_b", 32'(cscore0), 32'd7);
        check("lit_buf0_b", 32'(buffer[0]), 32'h80);

        // Saturated outputs: ties at +127 keep index 0, the rest clamp to -128.
        wz0 = '{100, 100, -100, -100, -100, -100, -100, -100, -100, -100};
        wz1 = '{100, 100, -100, -100, -100, -100, -100, -100, -100, -100};
        bz  = '{0, 10, 0, 0, 0, 0, 0, 0, 0, 0};
        set_pattern_vals(wz0, wz1, bz);
        run0(lat);
        check("lit_class_idx_c", 32'(cidx0), 32'd0);
        check("lit_class_score_c", 32'(cscore0), 32'h7F);
        check("lit_buf5_c", 32'(buffer[5]), 32'h80);

        // start held high: one run per IDLE entry, back-to-back dones 52 apart.
        set_pattern_a();
        start0 = 1'b1;
        t0 = cyc;
        wait_done(d_a);
        check("lit_held_first", 32'(d_a - t0), 32'd51);
        wait_done(d_b);
        start0 = 1'b0;
        check("lit_held_gap", 32'(d_b - d_a), 32'd52);
        repeat (60) begin @(posedge clk); #1; end

        // Reset in the middle of a run.
        start0 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0;
        repeat (19) @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        check("mid_rst_busy", 32'(busy0), 32'd0);
        check("mid_rst_done", 32'(done0), 32'd0);
        check("mid_rst_out_we", 32'(we0), 32'd0);
        check("mid_rst_rom_addr", 32'(rom_addr0), 32'd0);
        check("mid_rst_weight", nw0, 32'd0);
        check("mid_rst_bias", 32'(nb0), 32'd0);
        check("mid_rst_class_idx", 32'(cidx0), 32'd0);
        check("mid_rst_class_score", 32'(cscore0), 32'd0);
        check("mid_rst_out_data", 32'(odata0), 32'd0);
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b1;
        ndone = 0;
        repeat (60) begin
            @(negedge clk);
            if (done0) ndone++;
        end
        check("no_done_after_reset", 32'(ndone), 32'd0);
        @(posedge clk); #1;
        run0(lat);
        check("lat_after_reset", 32'(lat), 32'd51);
        check("lit_class_idx_r", 32'(cidx0), 32'd9);
        check("lit_class_score_r", 32'(cscore0), 32'd13);

        // Single-neuron, latency-1 instance: write at rel 4, done at rel 5.
        start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        for (int rel = 1; rel <= 7; rel++) begin
            @(negedge clk);
            check("n1_busy", 32'(busy1), 32'(rel <= 5));
            check("n1_out_we", 32'(we1), 32'(rel == 4));
            check("n1_done", 32'(done1), 32'(rel == 5));
            check("n1_rom_addr", 32'(rom_addr1), 32'd0);
            if (rel == 4) begin
                check("n1_out_addr", 32'(oaddr1), 32'd0);
                check("n1_out_data", 32'(odata1), 32'd3);
            end
            if (rel >= 5) begin
                check("n1_class_idx", 32'(cidx1), 32'd0);
                check("n1_class_score", 32'(cscore1), 32'd3);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/neuron_layer_scheduler.md
# neuron_layer_scheduler

Sequencer that time-multiplexes one `neuron_wrapper` datapath across all `num_neurons` neurons of a fully-connected layer. Per neuron it fetches that neuron's weight vector and bias from a parameter ROM, drives them into the neuron, waits out the neuron latency and writes the neuron output into a layer result buffer. While doing so it tracks a running signed argmax, so the final layer directly yields the recognised digit. The scheduler sits between the layer parameter ROM, a shared neuron instance and the result buffer; upstream holds `input_data` on the neuron stable while `busy` is high.

## Interface
- `input_data_size`, 4: inputs per neuron (elements in the weight vector).
- `resolution`, 8: bit width of each signed weight, bias and output.
- `num_neurons`, 10: neurons in the layer; must be ≥ 1.
- `neuron_latency`, 2: cycles from a `neuron_weight`/`neuron_bias` update to a valid `neuron_output`; must be ≥ 1.
- `AW` (localparam): max(1, $clog2(`num_neurons`)).
- `clk`  in  1  single clock; all logic on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  run request; sampled only in IDLE.
- `busy`  out  1  high from the cycle after `start` is accepted until the end of DONE.
- `done`  out  1  one-cycle pulse; run complete.
- `rom_addr`  out  AW  neuron index into the parameter ROM; ROM read latency is 1 cycle.
- `rom_weight`  in  resolution*input_data_size  flattened signed weights for `rom_addr`.
- `rom_bias`  in  resolution  signed bias for `rom_addr`.
- `neuron_weight`  out  resolution*input_data_size  registered weights to the neuron.
- `neuron_bias`  out  resolution  registered bias to the neuron.
- `neuron_output`  in  resolution  signed neuron result.
- `out_we`  out  1  result buffer write strobe.
- `out_addr`  out  AW  result buffer address, equal to the neuron index.
- `out_data`  out  resolution  result buffer write data.
- `class_idx`  out  AW  index of the maximum output of the last completed run.
- `class_score`  out  resolution  signed maximum output of the last completed run.

## Operation
- FSM states: IDLE, FETCH, LOAD, WAIT, STORE, DONE.
- IDLE: when `start` is high, clear `idx`, clear the running max and go to FETCH. Otherwise stay in IDLE.
- FETCH: drive `rom_addr` = `idx`; go to LOAD.
- LOAD: register `rom_weight` → `neuron_weight` and `rom_bias` → `neuron_bias`; load the wait counter with `neuron_latency`; go to WAIT.
- WAIT: decrement the counter each cycle. When it reaches 0, go to STORE. WAIT therefore lasts exactly `neuron_latency` cycles.
- STORE: for one cycle, `out_we` = 1, `out_addr` = `idx`, `out_data` = `neuron_output`.
  - Argmax update: if `idx` = 0, or `neuron_output` > running max (signed, strict), take `neuron_output` as the new max and `idx` as the max index. Ties keep the lower index.
  - If `idx` = `num_neurons`-1, go to DONE. Otherwise increment `idx` and go to FETCH.
- DONE: `done` = 1 for one cycle. `class_idx`/`class_score` update from the running max on entry to DONE and then hold until the next DONE. Return to IDLE.
- `start` outside IDLE, including during DONE, is ignored; it is not queued.
- `neuron_weight`/`neuron_bias` hold their last value outside LOAD.
- `rom_addr` holds `idx` in every state.
- No arithmetic is performed on the data; `out_data` is passed through unmodified.

## Timing
- Reset values of every output: `busy` 0, `done` 0, `out_we` 0, `out_addr` 0, `out_data` 0, `rom_addr` 0, `neuron_weight` 0, `neuron_bias` 0, `class_idx` 0, `class_score` 0; state IDLE.
- Per neuron: 3 + `neuron_latency` cycles (FETCH, LOAD, WAIT×L, STORE).
- `start` is accepted at edge t0; `done` is high during the cycle beginning at edge t0 + 1 + `num_neurons`·(3+`neuron_latency`). With the default parameters (N=10, L=2) that is t0+51.
- `busy` goes high at t0+1 and falls at the edge that ends DONE.
- A new `start` is accepted at the earliest in the first IDLE cycle after DONE.
- Reset asserted mid-run: immediate return to IDLE with all outputs at their reset values. Buffer contents already written are not cleared, and no `done` is produced.
- `num_neurons` = 1: a single FETCH/LOAD/WAIT/STORE pass, then DONE; `class_idx` = 0.

## Test plan
- Reset: assert `reset`=0 asynchronously mid-cycle → all outputs 0 immediately; release, `start`=0 for 10 cycles → `busy`=0, `out_we`=0.
- Full run, defaults: ROM[n] weights {n,1,1,1}, bias 1, `input_data` {1,1,1,1} on a behavioural neuron model (output = dot + bias, saturated, 2-cycle latency) → 10 writes at addresses 0..9 with data n+4; `done` at t0+51; `class_idx`=9, `class_score`=13.
- Argmax signed/tie: outputs forced {-128, 5, 7, -3, 7, 0, …, 0} → `class_idx`=2, `class_score`=7 (tie at index 4 and negatives handled).
- `start` held high for the whole run and in DONE → exactly one run per IDLE entry; second run's `done` at t0+52+51.
- Reset at cycle 20 of a run → outputs reset, no `done`; a fresh `start` then completes normally in 51 cycles.
- `num_neurons`=1, `neuron_latency`=1 → one write to address 0, `done` at t0+5.
